receptor_serie_6bit: RTL

Serial-to-parallel front end for the 6-bit set comparator: assembles 6-bit words arriving MSB-first on a bit-strobed serial line and presents each completed word on a registered `Entrada` bus that drives the comparator input. It samples the comparator's combinational `Salida` one cycle after each new word and latches the membership result. It also keeps a saturating count of words that matched.

---
 rtl/receptor_serie_6bit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/receptor_serie_6bit.sv
`default_nettype none
// ============================================================================
// Module   : receptor_serie_6bit
// Brief    : MSB-first serial-to-parallel receiver feeding a 6-bit set
//            comparator; latches the comparator verdict and counts matches.
// Revision : 1.0 - initial release
// ============================================================================
module receptor_serie_6bit #(
    parameter int ANCHO_CONTADOR = 8
) (
    input  logic                      Reloj,
    input  logic                      Reset,
    input  logic                      DatoSerie,
    input  logic                      Habilita,
    input  logic                      Inicio,
    input  logic                      Coincide,
    output logic [5:0]                Entrada,
    output logic                      Valido,
    output logic                      Resultado,
    output logic                      ResultadoValido,
    output logic [ANCHO_CONTADOR-1:0] Coincidencias,
    output logic                      ErrorTrama,
    output logic                      Ocupado
);

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        RECIBIENDO = 2'd1,
        EVALUANDO  = 2'd2
    } estado_t;

    localparam logic [ANCHO_CONTADOR-1:0] C_CUENTA_MAX = '1;

    estado_t                   estado_q, estado_d;
    logic [5:0]                despl_q, despl_d;
    logic [2:0]                bits_q, bits_d;
    logic [5:0]                entrada_q, entrada_d;
    logic                      valido_q, valido_d;
    logic                      resultado_q, resultado_d;
    logic                      res_valido_q, res_valido_d;
    logic [ANCHO_CONTADOR-1:0] cuenta_q, cuenta_d;
    logic                      error_q, error_d;
    logic [5:0]                despl_sig;

    assign despl_sig = {despl_q[4:0], DatoSerie};

    always_comb begin
        estado_d     = estado_q;
        despl_d      = despl_q;
        bits_d       = bits_q;
        entrada_d    = entrada_q;
        valido_d     = 1'b0;
        resultado_d  = resultado_q;
        res_valido_d = 1'b0;
        cuenta_d     = cuenta_q;
        error_d      = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (Inicio) begin
                    despl_d  = 6'd0;
                    bits_d   = 3'd0;
                    estado_d = RECIBIENDO;
                end
            end

            RECIBIENDO: begin
                // A new start mid-frame discards the partial word
                if (Inicio) begin
                    despl_d = 6'd0;
                    bits_d  = 3'd0;
                    error_d = 1'b1;
                end else if (Habilita) begin
                    despl_d = despl_sig;
                    bits_d  = bits_q + 3'd1;
                    if (bits_q == 3'd5) begin
                        entrada_d = despl_sig;
                        valido_d  = 1'b1;
                        estado_d  = EVALUANDO;
                    end
                end
            end

            EVALUANDO: begin
                resultado_d  = Coincide;
                res_valido_d = 1'b1;
                if (Coincide && (cuenta_q != C_CUENTA_MAX)) begin
                    cuenta_d = cuenta_q + 1'b1;
                end
                if (Inicio) begin
                    despl_d  = 6'd0;
                    bits_d   = 3'd0;
                    estado_d = RECIBIENDO;
                end else begin
                    estado_d = REPOSO;
                end
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            estado_q     <= REPOSO;
            despl_q      <= 6'd0;
            bits_q       <= 3'd0;
            entrada_q    <= 6'd0;
            valido_q     <= 1'b0;
            resultado_q  <= 1'b0;
            res_valido_q <= 1'b0;
            cuenta_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            despl_q      <= despl_d;
            bits_q       <= bits_d;
            entrada_q    <= entrada_d;
            valido_q     <= valido_d;
            resultado_q  <= resultado_d;
            res_valido_q <= res_valido_d;
            cuenta_q     <= cuenta_d;
            error_q      <= error_d;
        end
    end

    assign Entrada         = entrada_q;
    assign Valido          = valido_q;
    assign Resultado       = resultado_q;
    assign ResultadoValido = res_valido_q;
    assign Coincidencias   = cuenta_q;
    assign ErrorTrama      = error_q;
    assign Ocupado         = (estado_q != REPOSO);

endmodule
`default_nettype wire
